// File: rtl/uart_cmd_framer.sv
// Assembles UART receiver bytes into 5-byte command frames (ID + 32-bit big-endian payload),
// with an inter-byte timeout, command-range checking and an ACK/NAK response byte.
module uart_cmd_framer #(
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned MAX_CMD        = 15,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_busy,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_id,
  output logic [31:0] cmd_payload,
  output logic        frame_err,
  output logic        timeout_err,
  output logic        ack_valid,
  output logic [7:0]  ack_data,
  input  logic        ack_ready,
  output logic        ack_overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TC_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TC_EXPIRE = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic {IDLE, PAYLOAD} state_t;

  state_t        state, state_next;
  logic [2:0]    cnt, cnt_next;
  logic [TW-1:0] tcnt, tcnt_next;
  logic [7:0]    cmd_byte, cmd_byte_next;
  logic [31:0]   shift_reg, shift_next;
  logic          prev_busy;
  logic          strobe;
  logic          frame_done;
  logic          expire;
  logic          legal;
  logic          resp_push;
  logic [7:0]    resp_byte;

  function automatic logic is_legal(input logic [7:0] id);
    return ({24'd0, id} <= 32'(MAX_CMD)) && (id != 8'd13) && (id != 8'd14);
  endfunction

  // Byte completion is the falling edge of the receiver busy flag.
  assign strobe = prev_busy & ~rx_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_busy <= 1'b0;
      state     <= IDLE;
      cnt       <= 3'd0;
      tcnt      <= '0;
    end else begin
      prev_busy <= rx_busy;
      state     <= state_next;
      cnt       <= cnt_next;
      tcnt      <= tcnt_next;
    end
  end

  // Frame contents are plain data and need no reset; the FSM never reads them in IDLE.
  always_ff @(posedge clk) begin
    cmd_byte  <= cmd_byte_next;
    shift_reg <= shift_next;
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    tcnt_next     = tcnt;
    cmd_byte_next = cmd_byte;
    shift_next    = shift_reg;
    frame_done    = 1'b0;
    expire        = 1'b0;
    case (state)
      IDLE: begin
        tcnt_next = '0;
        if (strobe) begin
          cmd_byte_next = rx_data;
          shift_next    = 32'd0;
          cnt_next      = 3'd1;
          state_next    = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (strobe) begin
          shift_next = {shift_reg[23:0], rx_data};
          tcnt_next  = '0;
          if (cnt == 3'd4) begin
            frame_done = 1'b1;
            cnt_next   = 3'd0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + 3'd1;
          end
        end else if (tcnt == TC_EXPIRE) begin
          // Expire on the cycle the count would reach TIMEOUT_CYCLES-1; a strobe here wins.
          expire     = 1'b1;
          cnt_next   = 3'd0;
          tcnt_next  = '0;
          state_next = IDLE;
        end else if (tcnt != TC_LAST) begin
          tcnt_next = tcnt + TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign legal     = is_legal(cmd_byte);
  assign resp_push = frame_done | expire;
  assign resp_byte = (frame_done && legal) ? ACK_BYTE : NAK_BYTE;

  // Output stage: strobes and the accepted command, one cycle after the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid   <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      cmd_id      <= 8'd0;
      cmd_payload <= 32'd0;
    end else begin
      cmd_valid   <= frame_done & legal;
      frame_err   <= frame_done & ~legal;
      timeout_err <= expire;
      if (frame_done && legal) begin
        cmd_id      <= cmd_byte;
        cmd_payload <= shift_next;
      end
    end
  end

  // Single-entry response slot; a new response replaces an unconsumed one and flags it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_valid   <= 1'b0;
      ack_data    <= 8'd0;
      ack_overrun <= 1'b0;
    end else if (resp_push) begin
      ack_valid <= 1'b1;
      ack_data  <= resp_byte;
      if (ack_valid && !ack_ready) ack_overrun <= 1'b1;
    end else if (ack_valid && ack_ready) begin
      ack_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed bench for uart_cmd_framer: table of complete frames plus hand sequences for
// timeout, strobe/expiry collision, response overrun and mid-frame reset.
module tb_uart_cmd_framer;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_busy = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        ack_ready = 1'b1;
  logic        cmd_valid, frame_err, timeout_err, ack_valid, ack_overrun;
  logic [7:0]  cmd_id, ack_data;
  logic [31:0] cmd_payload;

  int passed = 0;
  int total  = 0;
  int n_valid = 0, n_ferr = 0, n_tmo = 0;

  uart_cmd_framer #(.TIMEOUT_CYCLES(TO), .MAX_CMD(15), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
    .clk(clk), .rst(rst), .rx_busy(rx_busy), .rx_data(rx_data),
    .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_payload(cmd_payload),
    .frame_err(frame_err), .timeout_err(timeout_err),
    .ack_valid(ack_valid), .ack_data(ack_data), .ack_ready(ack_ready),
    .ack_overrun(ack_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_valid)   n_valid++;
    if (frame_err)   n_ferr++;
    if (timeout_err) n_tmo++;
  end

  typedef struct {
    logic [39:0] bytes;
    logic        exp_valid;
    logic        exp_ferr;
    logic [7:0]  exp_id;
    logic [31:0] exp_pay;
    logic [7:0]  exp_ack;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Busy for one sampled edge, then low: the strobe cycle follows, and the byte is
  // accepted at the next edge. Returns just after that accepting edge.
  task automatic send_byte(input logic [7:0] b);
    rx_busy = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_busy = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 0; i < 5; i++) send_byte(f[39-8*i -: 8]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " cmd_valid"},   32'(cmd_valid),   32'd0);
    check({tag, " cmd_id"},      32'(cmd_id),      32'd0);
    check({tag, " cmd_payload"}, cmd_payload,      32'd0);
    check({tag, " frame_err"},   32'(frame_err),   32'd0);
    check({tag, " timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, " ack_valid"},   32'(ack_valid),   32'd0);
    check({tag, " ack_data"},    32'(ack_data),    32'd0);
    check({tag, " ack_overrun"}, 32'(ack_overrun), 32'd0);
  endtask

  initial begin
    int first_k, n_hi, snap_v, snap_f, snap_t;
    logic [7:0] ack_at_tmo;
    logic       ackv_at_tmo;

    vecs[0] = '{40'h02_12345678, 1'b1, 1'b0, 8'h02, 32'h12345678, 8'h06};
    vecs[1] = '{40'h0D_00000001, 1'b0, 1'b1, 8'h02, 32'h12345678, 8'h15};
    vecs[2] = '{40'h14_00000001, 1'b0, 1'b1, 8'h02, 32'h12345678, 8'h15};
    vecs[3] = '{40'h0E_AABBCCDD, 1'b0, 1'b1, 8'h02, 32'h12345678, 8'h15};
    vecs[4] = '{40'h0F_DEADBEEF, 1'b1, 1'b0, 8'h0F, 32'hDEADBEEF, 8'h06};
    vecs[5] = '{40'h10_01020304, 1'b0, 1'b1, 8'h0F, 32'hDEADBEEF, 8'h15};
    vecs[6] = '{40'h00_00000000, 1'b1, 1'b0, 8'h00, 32'h00000000, 8'h06};
    vecs[7] = '{40'h0C_CAFEF00D, 1'b1, 1'b0, 8'h0C, 32'hCAFEF00D, 8'h06};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].bytes);
      check($sformatf("v%0d cmd_valid", v),   32'(cmd_valid), 32'(vecs[v].exp_valid));
      check($sformatf("v%0d frame_err", v),   32'(frame_err), 32'(vecs[v].exp_ferr));
      check($sformatf("v%0d cmd_id", v),      32'(cmd_id),    32'(vecs[v].exp_id));
      check($sformatf("v%0d cmd_payload", v), cmd_payload,    vecs[v].exp_pay);
      check($sformatf("v%0d ack_valid", v),   32'(ack_valid), 32'd1);
      check($sformatf("v%0d ack_data", v),    32'(ack_data),  32'(vecs[v].exp_ack));
      @(posedge clk); #1;
      check($sformatf("v%0d cmd_valid end", v), 32'(cmd_valid), 32'd0);
      check($sformatf("v%0d frame_err end", v), 32'(frame_err), 32'd0);
      check($sformatf("v%0d ack_valid end", v), 32'(ack_valid), 32'd0);
    end

    // Timeout: two bytes then silence; pulse expected 49 edges after the 2nd byte's accepting edge.
    send_byte(8'h05);
    send_byte(8'hAA);
    first_k = -1;
    n_hi = 0;
    ack_at_tmo = 8'd0;
    ackv_at_tmo = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (timeout_err) begin
        n_hi++;
        if (first_k < 0) begin
          first_k = k;
          ack_at_tmo = ack_data;
          ackv_at_tmo = ack_valid;
        end
      end
    end
    check("tmo latency",   32'(first_k),     32'd49);
    check("tmo width",     32'(n_hi),        32'd1);
    check("tmo ack_valid", 32'(ackv_at_tmo), 32'd1);
    check("tmo ack_data",  32'(ack_at_tmo),  32'h15);
    check("tmo cmd_id",    32'(cmd_id),      32'h0C);
    check("tmo payload",   cmd_payload,      32'hCAFEF00D);
    send_frame(40'h0F_00000000);
    check("post-tmo cmd_valid", 32'(cmd_valid), 32'd1);
    check("post-tmo cmd_id",    32'(cmd_id),    32'h0F);
    check("post-tmo payload",   cmd_payload,    32'h0);
    @(posedge clk); #1;

    // 3rd byte strobe in the very cycle the counter would expire.
    snap_t = n_tmo;
    send_byte(8'h03);
    send_byte(8'h11);
    rx_busy = 1'b1;
    rx_data = 8'h22;
    repeat (TO - 2) @(posedge clk);
    #1;
    rx_busy = 1'b0;
    @(posedge clk); #1;
    send_byte(8'h33);
    send_byte(8'h44);
    check("collide cmd_valid", 32'(cmd_valid), 32'd1);
    check("collide cmd_id",    32'(cmd_id),    32'h03);
    check("collide payload",   cmd_payload,    32'h11223344);
    @(negedge clk); #1;
    check("collide no timeout", 32'(n_tmo - snap_t), 32'd0);
    @(posedge clk); #1;

    // Back-to-back legal frames with the transmitter stalled.
    ack_ready = 1'b0;
    send_frame(40'h01_11111111);
    check("ovr first ack_valid", 32'(ack_valid),   32'd1);
    check("ovr first overrun",   32'(ack_overrun), 32'd0);
    send_frame(40'h02_22222222);
    check("ovr cmd_id",     32'(cmd_id),      32'h02);
    check("ovr ack_valid",  32'(ack_valid),   32'd1);
    check("ovr ack_data",   32'(ack_data),    32'h06);
    check("ovr overrun",    32'(ack_overrun), 32'd1);
    ack_ready = 1'b1;
    @(posedge clk); #1;
    check("ovr drained ack_valid", 32'(ack_valid),   32'd0);
    check("ovr sticky overrun",    32'(ack_overrun), 32'd1);

    // Reset after three bytes abandons the frame.
    send_byte(8'h07);
    send_byte(8'h01);
    send_byte(8'h02);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    snap_v = n_valid;
    snap_f = n_ferr;
    send_frame(40'h01_00000003);
    check("rst frame cmd_valid", 32'(cmd_valid), 32'd1);
    check("rst frame cmd_id",    32'(cmd_id),    32'h01);
    check("rst frame payload",   cmd_payload,    32'h3);
    @(negedge clk); #1;
    check("rst frame valid count", 32'(n_valid - snap_v), 32'd1);
    check("rst frame ferr count",  32'(n_ferr - snap_f),  32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
